// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream
// Drains the read port of an asynchronous FIFO (read-clock side) into a
// valid/ready stream through a 2-entry in-order skid buffer. The FIFO returns
// read data exactly one cycle after rinc; rinc is only issued when the word
// it requests is guaranteed a buffer slot, so the buffer can never overflow.
//
// Optional feature: define AFIFO_RD_STREAM_CNT_EN to add a 16-bit beat_cnt
// output counting accepted stream beats (wraps at 16'hFFFF).
//
// Ports:
//   rclk        read-domain clock
//   rrst_n      asynchronous active-low reset
//   srst        synchronous active-high soft reset
//   rempty      FIFO empty flag
//   rdata_valid FIFO read data valid (one cycle after rinc)
//   rdata       FIFO read data
//   rinc        FIFO read enable (combinational, depends on m_ready)
//   m_valid     stream valid
//   m_data      stream data (oldest buffered word)
//   m_ready     stream ready
//   beat_cnt    accepted-beat counter (AFIFO_RD_STREAM_CNT_EN only)
//   proto_err   sticky flag: rdata_valid seen without a request in flight
module afifo_rd_stream #(
  parameter int DW = 10
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          srst,
  input  logic          rempty,
  input  logic          rdata_valid,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
`ifdef AFIFO_RD_STREAM_CNT_EN
  output logic [15:0]   beat_cnt,
`endif
  output logic          proto_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] head_r;
  logic [DW-1:0] tail_r;
  logic [DW-1:0] head_s;
  logic [DW-1:0] tail_s;
  logic          inflight_r;
  logic          srst_d_r;
  logic          proto_err_r;
  logic [1:0]    occ;
  logic          pop;
  logic          push;
  logic [2:0]    level_s;

  // Entry count decoded from the buffer state.
  always_comb begin
    occ = 2'd0;
    case (state_r)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign m_valid   = (occ != 2'd0);
  assign m_data    = head_r;
  assign proto_err = proto_err_r;
  assign pop       = m_valid & m_ready;
  assign push      = rdata_valid & inflight_r;

  // Slots committed after this cycle's pop: a new read is allowed only if at
  // most one is taken, which also rules out push+pop while holding two words.
  assign level_s = {1'b0, occ} + {2'b00, inflight_r} - {2'b00, pop};
  // rrst_n gating keeps rinc low for the whole reset, not just after an edge.
  assign rinc    = rrst_n & ~rempty & ~srst & (level_s <= 3'd1);

  // Next buffer state and data: push appends behind head, pop advances head.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push) begin
          state_s = ONE;
          head_s  = rdata;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (push && pop) begin
          state_s = ONE;
          head_s  = rdata;
        end else if (push) begin
          state_s = TWO;
          tail_s  = rdata;
        end else if (pop) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      TWO: begin
        if (pop) begin
          state_s = ONE;
          head_s  = tail_r;
        end else begin
          state_s = TWO;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // Buffer, in-flight tracking and sticky protocol error.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r     <= EMPTY;
      head_r      <= {DW{1'b0}};
      tail_r      <= {DW{1'b0}};
      inflight_r  <= 1'b0;
      srst_d_r    <= 1'b0;
      proto_err_r <= 1'b0;
    end else if (srst) begin
      state_r     <= EMPTY;
      head_r      <= {DW{1'b0}};
      tail_r      <= {DW{1'b0}};
      inflight_r  <= 1'b0;
      srst_d_r    <= 1'b1;
      proto_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      inflight_r <= rinc;
      srst_d_r   <= 1'b0;
      // A late response to a read issued before srst is dropped silently.
      if (rdata_valid && !inflight_r && !srst_d_r) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

`ifdef AFIFO_RD_STREAM_CNT_EN
  logic [15:0] beat_cnt_r;

  // Accepted-beat counter, wraps naturally at 16 bits.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt_r <= 16'd0;
    end else if (srst) begin
      beat_cnt_r <= 16'd0;
    end else if (pop) begin
      beat_cnt_r <= beat_cnt_r + 16'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt = beat_cnt_r;
`endif

endmodule
